// File: rtl/adder8_seq_arb.sv
// adder8_seq_arb: two-requester round-robin front end to a byte-serial adder.
// A single 8-bit ripple adder is reused once per byte, LSB first, with a
// registered carry linking the bytes. A result is presented NBYTES cycles
// after acceptance and held until the consumer takes it.
// Optional feature: define ADDER8_SEQ_OVF_EN to add the rsp_ovf output
// (two's-complement signed overflow of the full-width add).

// 8-bit ripple-carry adder, the per-byte arithmetic element.
module adder8_ripple (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_c;

  // Bit-serial carry chain from bit 0 up to bit 7.
  always_comb begin
    w_c[0] = i_cin;
    o_sum  = '0;
    for (int i = 0; i < 8; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[8];

endmodule

module adder8_seq_arb #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id,
  output logic                  busy
`ifdef ADDER8_SEQ_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_carry;
  logic                     r_last;
  logic                     r_id;
  logic                     r_cout;
  logic [NBYTES-1:0][7:0]   r_a;
  logic [NBYTES-1:0][7:0]   r_b;
  logic [NBYTES-1:0][7:0]   r_sum;
`ifdef ADDER8_SEQ_OVF_EN
  logic                     r_ovf;
`endif

  logic                     w_grant_valid;
  logic                     w_grant_id;
  logic                     w_accept;
  logic                     w_last_byte;
  logic [7:0]               w_a_byte;
  logic [7:0]               w_b_byte;
  logic [7:0]               w_byte_sum;
  logic                     w_byte_cout;

  assign w_a_byte    = r_a[r_cnt];
  assign w_b_byte    = r_b[r_cnt];
  assign w_last_byte = (r_state == S_ADD) && (r_cnt == LAST_BYTE);

  adder8_ripple u_add (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_byte_sum),
    .o_cout (w_byte_cout)
  );

  // Round-robin grant and ready handshake, offered only while idle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_grant_valid = req0_valid | req1_valid;
    w_grant_id    = 1'b0;
    if (req0_valid && req1_valid) w_grant_id = ~r_last;
    else                          w_grant_id = req1_valid;
    w_accept      = (r_state == S_IDLE) && w_grant_valid;
    req0_ready    = (r_state == S_IDLE) && req0_valid && !w_grant_id;
    req1_ready    = (r_state == S_IDLE) && req1_valid &&  w_grant_id;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    rsp_valid    = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = S_ADD;
      S_ADD:   if (w_last_byte) w_next_state = S_DONE;
      S_DONE:  if (rsp_ready)   w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // Operand capture on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are always loaded on
    // acceptance before the adder reads them.
    if (w_accept) begin
      r_a <= w_grant_id ? req1_a : req0_a;
      r_b <= w_grant_id ? req1_b : req0_b;
    end
  end

  // State register, byte counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
`ifdef ADDER8_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt   <= '0;
        r_carry <= w_grant_id ? req1_cin : req0_cin;
        r_id    <= w_grant_id;
        r_last  <= w_grant_id;
      end else if (r_state == S_ADD) begin
        r_sum[r_cnt] <= w_byte_sum;
        r_carry      <= w_byte_cout;
        r_cnt        <= r_cnt + 1'b1;
        if (w_last_byte) begin
          r_cout <= w_byte_cout;
`ifdef ADDER8_SEQ_OVF_EN
          // Carry into the MSB recovered from the MSB's sum and operand bits.
          r_ovf  <= (w_byte_sum[7] ^ w_a_byte[7] ^ w_b_byte[7]) ^ w_byte_cout;
`endif
        end
      end
    end
  end

  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_id   = r_id;
`ifdef ADDER8_SEQ_OVF_EN
  assign rsp_ovf  = r_ovf;
`endif

endmodule

// File: doc/adder8_seq_arb.md
ADDER8_SEQ_ARB -- requirements
Module: adder8_seq_arb

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes; W = 8*NBYTES; legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have ports req0_valid, input, 1 and req1_valid, input, 1: requester operand valid.
REQ-005 The block SHALL have ports req0_ready, output, 1 and req1_ready, output, 1: operand accepted this cycle when ANDed with the matching valid.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each: the operands.
REQ-007 The block SHALL have ports req0_cin, input, 1 and req1_cin, input, 1: the carry-in.
REQ-008 The block SHALL have port rsp_valid, output, 1: a result is present.
REQ-009 The block SHALL have port rsp_ready, input, 1: the consumer takes the result.
REQ-010 The block SHALL have port rsp_sum, output, W: the sum.
REQ-011 The block SHALL have port rsp_cout, output, 1: the final carry.
REQ-012 The block SHALL have port rsp_id, output, 1: the requester served (0 or 1).
REQ-013 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL compute each result with exactly one instance of the team's 8-bit ripple adder, used one byte per cycle, LSB first, with a carry register chaining bytes.
REQ-015 The FSM SHALL have states IDLE, ADD and DONE; IDLE->ADD on an accepted request; ADD->DONE after byte NBYTES-1; DONE->IDLE when rsp_ready=1.
REQ-016 In IDLE the grant SHALL go to the only valid requester, or, with both valid, to the requester not served last (round-robin); ready SHALL be high only for the granted requester, combinationally, only in IDLE.
REQ-017 On acceptance the block SHALL capture a, b, cin and id into internal registers; later changes to requester inputs SHALL NOT affect the result.
REQ-018 In ADD the byte counter SHALL run 0..NBYTES-1; byte k of sum = a[8k+7:8k] + b[8k+7:8k] + carry; carry initialised to the captured cin.
REQ-019 Latency: for acceptance at edge T, rsp_valid SHALL rise at edge T+NBYTES and rsp_sum, rsp_cout and rsp_id SHALL be stable while rsp_valid=1.
REQ-020 In DONE, rsp_valid SHALL hold until rsp_ready=1; no new request SHALL be accepted in ADD or DONE, and with rsp_ready held high at least one idle cycle SHALL separate back-to-back results.
REQ-021 rsp_ready while rsp_valid=0 SHALL have no effect; requesters that withdraw valid before acceptance SHALL lose nothing.
REQ-022 Arithmetic SHALL be modulo 2^W with the carry out of bit W-1 on rsp_cout; example: all-ones + 0 + cin=1 gives sum 0 and cout 1.

Reset
REQ-023 With rst_n=0 at a rising edge the block SHALL go to IDLE, clear the counter, carry, rsp_sum, rsp_cout and rsp_id, and set last-served to 1 so req0 wins the first tie.
REQ-024 During reset and the first cycle after it, rsp_valid and busy SHALL be 0; req*_ready SHALL follow REQ-016 from IDLE.
REQ-025 Reset asserted mid-ADD or in DONE SHALL abort the operation with no result ever presented.

Configuration
REQ-026 With macro ADDER8_SEQ_OVF_EN defined, the block SHALL add output rsp_ovf, 1 bit, equal to two's-complement signed overflow of the W-bit add (carry into MSB XOR carry out) and valid with rsp_valid, reset 0.
REQ-027 With ADDER8_SEQ_OVF_EN undefined, port rsp_ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL drive req0 a=0x000000FF, b=0x00000001, cin=0, rsp_ready=1 and check rsp_sum=0x00000100, cout=0, id=0, rsp_valid 4 cycles after acceptance.
REQ-029 The bench SHALL drive req1 a=0xFFFFFFFF, b=0, cin=1 and check sum=0x00000000, cout=1, id=1; with OVF_EN also check ovf=0.
REQ-030 The bench SHALL hold req0 and req1 valid continuously for 4 transactions and check grants alternate 0,1,0,1 starting with 0 after reset.
REQ-031 The bench SHALL hold rsp_ready=0 for 10 cycles after rsp_valid and check the result is held stable, busy=1 and both ready=0, then a single rsp_ready pulse returns the block to IDLE.
REQ-032 The bench SHALL assert rst_n=0 at byte 2 of an add and check no rsp_valid appears afterwards and the next request produces a correct result.
REQ-033 With OVF_EN, the bench SHALL add 0x7FFFFFFF+0x00000001 and check sum=0x80000000, ovf=1, cout=0.
